stream_demux_1to2: RTL and testbench

- Buffered 1-to-2 word router: the inverse of the datapath 2:1 select mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it to output 0 or output 1 by a select bit.
- Each output has its own DEPTH-entry FIFO, so a stalled consumer on one output does not block traffic to the other.
- Used to split a single result stream between two downstream consumers, e.g. a register-file write path and a memory write path.

---
 rtl/stream_demux_1to2_if.sv | 39 +++
 rtl/stream_demux_1to2.sv | 100 ++++++++++
 tb/tb_stream_demux_1to2.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for stream_demux_1to2.
//   in_data/in_sel/in_valid/in_ready : single input stream, in_sel picks output 0 or 1
//   out0_*                           : output 0 stream (data, valid, ready)
//   out1_*                           : output 1 stream (data, valid, ready)
// slave modport is the demux side, master modport is the producer/consumer side.
interface stream_demux_1to2_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out0_data, out0_valid,
    input  out0_ready,
    output out1_data, out1_valid,
    input  out1_ready
  );

  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out0_data, out0_valid,
    output out0_ready,
    input  out1_data, out1_valid,
    output out1_ready
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// Buffered 1-to-2 word router. Each accepted input word is written into the
// FIFO selected by in_sel; each output drains its own DEPTH-entry FIFO, so a
// stalled consumer only blocks words headed for its own output.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; empties both FIFOs, clears counters
//   bus  : handshake bundle (slave side), see stream_demux_1to2_if
//   cnt0 : words accepted into FIFO 0 (wraps)
//   cnt1 : words accepted into FIFO 1 (wraps)
module stream_demux_1to2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_demux_1to2_if.slave    bus,
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [1:0] full_v;
  logic [1:0] out_ready_v;
  logic       in_fire;

  assign out_ready_v = {bus.out1_ready, bus.out0_ready};

  // Ready only looks at the registered full flag of the selected FIFO, so a
  // pop in the same cycle does not open room for a push until the next cycle.
  assign bus.in_ready = !rst && !full_v[bus.in_sel];
  assign in_fire      = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             full;
    logic             valid;

    assign push   = in_fire && (bus.in_sel == 1'(k));
    assign valid  = (occ != '0);
    assign pop    = valid && out_ready_v[k];
    assign full   = (occ == OCC_W'(DEPTH));
    assign rd_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        cnt    <= '0;
        head   <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt + 1'b1;
        end
        rd_ptr <= rd_nxt;
        if (push && !pop) begin
          occ <= occ + 1'b1;
        end else if (pop && !push) begin
          occ <= occ - 1'b1;
        end
        // The head register tracks the entry at the next read pointer. When
        // the incoming word lands exactly there (FIFO empty after this
        // cycle's pop), the memory write is not visible yet, so bypass it.
        if (push && (wr_ptr == rd_nxt)) begin
          head <= bus.in_data;
        end else begin
          head <= mem[rd_nxt];
        end
      end
    end
  end

  assign full_v = {g_fifo[1].full, g_fifo[0].full};

  assign bus.out0_data  = g_fifo[0].head;
  assign bus.out0_valid = g_fifo[0].valid;
  assign bus.out1_data  = g_fifo[1].head;
  assign bus.out1_valid = g_fifo[1].valid;

  assign cnt0 = g_fifo[0].cnt;
  assign cnt1 = g_fifo[1].cnt;

endmodule

// File: tb/tb_stream_demux_1to2.sv
module tb_stream_demux_1to2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  stream_demux_1to2_if #(.WIDTH(WIDTH)) bus ();

  stream_demux_1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitor: every output transfer is compared to the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out0_valid && bus.out0_ready) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out0_unexpected: got %0h expected nothing", bus.out0_data);
        end else begin
          chk("out0_data", 64'(bus.out0_data), 64'(exp0.pop_front()));
        end
      end
      if (bus.out1_valid && bus.out1_ready) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_unexpected: got %0h expected nothing", bus.out1_data);
        end else begin
          chk("out1_data", 64'(bus.out1_data), 64'(exp1.pop_front()));
        end
      end
    end
  end

  // Issue a word, record its expected delivery, wait for acceptance.
  // w returns the number of cycles the word waited with in_ready low.
  task automatic send(input logic [WIDTH-1:0] d, input logic s, output int w);
    if (s) exp1.push_back(d);
    else   exp0.push_back(d);
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w > 20) begin
        errors++;
        $display("FAIL send_timeout: word %0h still waiting after %0d cycles, required acceptance", d, w);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.in_data    = 32'h99;
    bus.in_sel     = 1'b0;
    bus.in_valid   = 1'b1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Reset state, with a word offered during reset
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   64'(bus.in_ready),   64'd0);
    chk("rst_out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("rst_out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("rst_out0_data",  64'(bus.out0_data),  64'd0);
    chk("rst_out1_data",  64'(bus.out1_data),  64'd0);
    chk("rst_cnt0",       64'(cnt0),           64'd0);
    chk("rst_cnt1",       64'(cnt1),           64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Single word to output 0: one cycle latency, valid for one cycle
    send(32'hDEADBEEF, 1'b0, w);
    chk("t1_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t1_out0_valid", 64'(bus.out0_valid), 64'd1);
    chk("t1_out0_data",  64'(bus.out0_data),  64'hDEADBEEF);
    chk("t1_cnt0",       64'(cnt0),           64'd1);
    chk("t1_cnt1",       64'(cnt1),           64'd0);
    @(negedge clk);
    chk("t1_out0_valid_drop", 64'(bus.out0_valid), 64'd0);
    @(posedge clk); #1;

    // Stalled output 1 does not block output 0
    bus.out1_ready = 1'b0;
    send(32'h11, 1'b1, w);
    chk("t2_w11", 64'(w), 64'd0);
    send(32'h22, 1'b1, w);
    chk("t2_w22", 64'(w), 64'd0);
    bus.in_data  = 32'h44;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t2_full_in_ready", 64'(bus.in_ready),  64'd0);
    chk("t2_out1_head",     64'(bus.out1_data), 64'h11);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send(32'h33, 1'b0, w);
    chk("t2_w33_other_output", 64'(w), 64'd0);
    fork
      send(32'h44, 1'b1, w);
      begin
        repeat (2) @(posedge clk);
        #1 bus.out1_ready = 1'b1;
      end
    join
    chk("t2_w44_after_release", 64'(w), 64'd3);
    repeat (3) @(negedge clk);
    chk("t2_cnt0", 64'(cnt0), 64'd2);
    chk("t2_cnt1", 64'(cnt1), 64'd3);
    @(posedge clk); #1;

    // Alternating select, both outputs ready
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      send(WIDTH'(i), (i % 2) == 0, w);
      chk("t3_no_stall", 64'(w), 64'd0);
    end
    @(negedge clk);
    chk("t3_cnt0", 64'(cnt0), 64'd2);
    chk("t3_cnt1", 64'(cnt1), 64'd2);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Full FIFO with simultaneous pop: push waits one cycle
    bus.out0_ready = 1'b0;
    send(32'hA, 1'b0, w);
    chk("t4_wA", 64'(w), 64'd0);
    send(32'hB, 1'b0, w);
    chk("t4_wB", 64'(w), 64'd0);
    bus.out0_ready = 1'b1;
    send(32'hC, 1'b0, w);
    chk("t4_wC_one_cycle", 64'(w), 64'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Reset mid-operation discards buffered words, accepts nothing
    bus.out0_ready = 1'b0;
    send(32'h55, 1'b0, w);
    send(32'h66, 1'b0, w);
    rst          = 1'b1;
    bus.in_data  = 32'h77;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t5_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    chk("t5_out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("t5_out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("t5_cnt0",       64'(cnt0),           64'd0);
    chk("t5_cnt1",       64'(cnt1),           64'd0);
    @(posedge clk); #1;
    bus.out0_ready = 1'b1;

    // Counter wrap on output 1
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = WIDTH'(i) + 32'h1000;
      exp1.push_back(WIDTH'(i) + 32'h1000);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt1_max", 64'(cnt1), 64'hFFFF);
    @(posedge clk); #1;
    send(32'hCAFE, 1'b1, w);
    chk("t6_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("t6_cnt1_wrap",   64'(cnt1),           64'd0);
    chk("t6_cnt0",        64'(cnt0),           64'd0);
    chk("t6_out1_valid",  64'(bus.out1_valid), 64'd1);
    chk("t6_out1_data",   64'(bus.out1_data),  64'hCAFE);

    repeat (3) @(negedge clk);
    chk("end_exp0_drained", 64'(exp0.size()), 64'd0);
    chk("end_exp1_drained", 64'(exp1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
